// File: rtl/fifo_async_pkg.sv
// Shared pointer helpers for the async FIFO read/write status generators.
// Functions work on a fixed 32-bit container; callers zero-extend and truncate to PTR_W.
package fifo_async_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int unsigned ptr_w(input int unsigned abits);
    return abits + 1;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, in log2 steps; zero upper bits do not disturb the result.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = g;
    for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1)
      b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/fifo_rempty_gen_if.sv
// Read-side status bus between the read pointer counter and fifo_rempty_gen.
interface fifo_rempty_gen_if #(
  parameter int unsigned ABITS = 10
);
  logic             rd_en;
  logic [ABITS:0]   rd_bin_ptr;
  logic [ABITS:0]   wr_gray_ptr;
  logic [ABITS:0]   rd_gray_ptr;
  logic             rd_empty;
  logic             rd_aempty;
  logic [ABITS:0]   rd_usedw;

  modport master (
    output rd_en, rd_bin_ptr, wr_gray_ptr,
    input  rd_gray_ptr, rd_empty, rd_aempty, rd_usedw
  );

  modport slave (
    input  rd_en, rd_bin_ptr, wr_gray_ptr,
    output rd_gray_ptr, rd_empty, rd_aempty, rd_usedw
  );
endinterface

// File: rtl/fifo_gray_sync.sv
// SYNC_STAGES-deep flop chain for moving a Gray pointer into another clock domain.
module fifo_gray_sync #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rempty_gen.sv
// Read-domain empty / almost-empty / used-word generator for the async FIFO.
// Status is computed from the post-read pointer so it lands on the same edge as the counter.
module fifo_rempty_gen
  import fifo_async_pkg::*;
#(
  parameter int unsigned ABITS       = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AEMPTY_THR  = 4
) (
  input  logic                rdclk,
  input  logic                rst,
  fifo_rempty_gen_if.slave    bus
);

  localparam int unsigned        PTR_W  = ptr_w(ABITS);
  localparam logic [PTR_W-1:0]   AE_THR = PTR_W'(AEMPTY_THR);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_rempty_gen: SYNC_STAGES must be >= 2");
  end
  if (64'(AEMPTY_THR) >= (64'd1 << ABITS)) begin : g_bad_thr
    $error("fifo_rempty_gen: AEMPTY_THR must be below 2**ABITS");
  end
  if (PTR_W > PTR_MAX_W) begin : g_bad_width
    $error("fifo_rempty_gen: ABITS too large for pointer helpers");
  end

  logic             rd_allow;
  logic [PTR_W-1:0] wq_gray;
  logic [PTR_W-1:0] wr_bin_sync;
  logic [PTR_W-1:0] rd_bin_next;
  logic [PTR_W-1:0] rd_gray_next;
  logic [PTR_W-1:0] used_next;

  fifo_gray_sync #(
    .WIDTH       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (rdclk),
    .rst (rst),
    .d   (bus.wr_gray_ptr),
    .q   (wq_gray)
  );

  always_comb begin
    rd_allow     = bus.rd_en & ~bus.rd_empty;
    rd_bin_next  = bus.rd_bin_ptr + {{(PTR_W-1){1'b0}}, rd_allow};
    rd_gray_next = PTR_W'(bin2gray(ptr_max_t'(rd_bin_next)));
    wr_bin_sync  = PTR_W'(gray2bin(ptr_max_t'(wq_gray)));
    used_next    = wr_bin_sync - rd_bin_next;
  end

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      bus.rd_gray_ptr <= '0;
      bus.rd_empty    <= 1'b1;
      bus.rd_aempty   <= 1'b1;
      bus.rd_usedw    <= '0;
    end else begin
      bus.rd_gray_ptr <= rd_gray_next;
      bus.rd_empty    <= (rd_gray_next == wq_gray);
      bus.rd_aempty   <= (used_next <= AE_THR);
      bus.rd_usedw    <= used_next;
    end
  end

endmodule

// File: tb/tb_fifo_rempty_gen.sv
// Directed and randomised-ratio checks of fifo_rempty_gen with ABITS=4, 2 sync stages, threshold 2.
module tb_fifo_rempty_gen;

  logic rdclk = 1'b0;
  logic wrclk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #14 rdclk = ~rdclk;
  always #5  wrclk = ~wrclk;

  fifo_rempty_gen_if #(.ABITS(4)) bus ();

  fifo_rempty_gen #(
    .ABITS       (4),
    .SYNC_STAGES (2),
    .AEMPTY_THR  (2)
  ) dut (
    .rdclk (rdclk),
    .rst   (rst),
    .bus   (bus)
  );

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Models the read pointer counter: advance only on a read accepted at this edge.
  task automatic rd_cycle();
    logic allow;
    allow = bus.rd_en & ~bus.rd_empty;
    @(posedge rdclk);
    #1;
    if (allow) bus.rd_bin_ptr = bus.rd_bin_ptr + 5'd1;
  endtask

  task automatic do_reset();
    @(negedge rdclk);
    rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.rd_bin_ptr = '0;
    bus.wr_gray_ptr = '0;
    repeat (2) @(posedge rdclk);
    @(negedge rdclk);
    rst = 1'b0;
    @(posedge rdclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.rd_bin_ptr = '0;
    bus.wr_gray_ptr = '0;
    repeat (2) @(posedge rdclk);
    #1 rst = 1'b0;
    bus.wr_gray_ptr = 5'b00001;
    repeat (4) @(posedge rdclk);
    @(negedge rdclk);
    rst = 1'b1;
    #1;
    checks++; if (bus.rd_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.rd_empty); end
    checks++; if (bus.rd_aempty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", bus.rd_aempty); end
    checks++; if (bus.rd_usedw !== 5'd0) begin failures++; $display("FAIL reset_usedw got=%0d exp=0", bus.rd_usedw); end
    checks++; if (bus.rd_gray_ptr !== 5'b00000) begin failures++; $display("FAIL reset_gray got=%b exp=00000", bus.rd_gray_ptr); end
    bus.wr_gray_ptr = '0;
    repeat (2) @(posedge rdclk);
    @(negedge rdclk);
    rst = 1'b0;
    @(posedge rdclk);
    #1;
  endtask

  task automatic test_write_latency();
    logic [4:0] exp_used [3] = '{5'd0, 5'd0, 5'd1};
    bus.wr_gray_ptr = 5'b00001;
    for (int e = 0; e < 3; e++) begin
      rd_cycle();
      checks++; if (bus.rd_empty !== (e < 2)) begin failures++; $display("FAIL wlat_empty edge=%0d got=%b exp=%b", e + 1, bus.rd_empty, (e < 2)); end
      checks++; if (bus.rd_usedw !== exp_used[e]) begin failures++; $display("FAIL wlat_usedw edge=%0d got=%0d exp=%0d", e + 1, bus.rd_usedw, exp_used[e]); end
      checks++; if (bus.rd_aempty !== 1'b1) begin failures++; $display("FAIL wlat_aempty edge=%0d got=%b exp=1", e + 1, bus.rd_aempty); end
    end
  endtask

  task automatic test_read_to_empty();
    bus.rd_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rd_cycle();
      checks++; if (bus.rd_empty !== 1'b1) begin failures++; $display("FAIL read_empty cyc=%0d got=%b exp=1", c, bus.rd_empty); end
      checks++; if (bus.rd_usedw !== 5'd0) begin failures++; $display("FAIL read_usedw cyc=%0d got=%0d exp=0", c, bus.rd_usedw); end
      checks++; if (bus.rd_gray_ptr !== 5'b00001) begin failures++; $display("FAIL read_gray cyc=%0d got=%b exp=00001", c, bus.rd_gray_ptr); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_levels();
    logic [4:0] wg  [3] = '{5'b11000, 5'b00010, 5'b00011};
    logic [4:0] eu  [3] = '{5'd16, 5'd3, 5'd2};
    logic       eae [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.wr_gray_ptr = wg[k];
      repeat (4) rd_cycle();
      checks++; if (bus.rd_usedw !== eu[k]) begin failures++; $display("FAIL level_usedw k=%0d got=%0d exp=%0d", k, bus.rd_usedw, eu[k]); end
      checks++; if (bus.rd_empty !== 1'b0) begin failures++; $display("FAIL level_empty k=%0d got=%b exp=0", k, bus.rd_empty); end
      checks++; if (bus.rd_aempty !== eae[k]) begin failures++; $display("FAIL level_aempty k=%0d got=%b exp=%b", k, bus.rd_aempty, eae[k]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.rd_bin_ptr = 5'd31;
    bus.wr_gray_ptr = 5'b00001;
    repeat (4) rd_cycle();
    checks++; if (bus.rd_usedw !== 5'd2) begin failures++; $display("FAIL wrap_usedw0 got=%0d exp=2", bus.rd_usedw); end
    checks++; if (bus.rd_gray_ptr !== 5'b10000) begin failures++; $display("FAIL wrap_gray0 got=%b exp=10000", bus.rd_gray_ptr); end
    bus.rd_en = 1'b1;
    rd_cycle();
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_gray_ptr !== 5'b00000) begin failures++; $display("FAIL wrap_gray1 got=%b exp=00000", bus.rd_gray_ptr); end
    checks++; if (bus.rd_usedw !== 5'd1) begin failures++; $display("FAIL wrap_usedw1 got=%0d exp=1", bus.rd_usedw); end
    checks++; if (bus.rd_empty !== 1'b0) begin failures++; $display("FAIL wrap_empty1 got=%b exp=0", bus.rd_empty); end
  endtask

  task automatic test_random_ratio();
    logic [4:0] wr_bin;
    do_reset();
    wr_bin = '0;
    fork
      begin
        logic [4:0] fill;
        repeat (600) begin
          @(posedge wrclk);
          #1;
          fill = wr_bin - bus.rd_bin_ptr;
          if (fill < 5'd16 && $urandom_range(0, 2) != 0) begin
            wr_bin = wr_bin + 5'd1;
            bus.wr_gray_ptr = g(wr_bin);
          end
        end
      end
      begin
        logic [4:0] prev_gray;
        logic [4:0] true_cnt;
        prev_gray = bus.rd_gray_ptr;
        repeat (200) begin
          bus.rd_en = 1'($urandom_range(0, 1));
          rd_cycle();
          true_cnt = wr_bin - bus.rd_bin_ptr;
          checks++; if (bus.rd_usedw > true_cnt) begin failures++; $display("FAIL rnd_usedw_true got=%0d max=%0d", bus.rd_usedw, true_cnt); end
          checks++; if (bus.rd_usedw > 5'd16) begin failures++; $display("FAIL rnd_usedw_depth got=%0d max=16", bus.rd_usedw); end
          checks++; if (bus.rd_empty !== (bus.rd_usedw == 5'd0)) begin failures++; $display("FAIL rnd_empty got=%b exp=%b", bus.rd_empty, (bus.rd_usedw == 5'd0)); end
          checks++; if (bus.rd_gray_ptr !== g(bus.rd_bin_ptr)) begin failures++; $display("FAIL rnd_gray got=%b exp=%b", bus.rd_gray_ptr, g(bus.rd_bin_ptr)); end
          checks++; if ($countones(bus.rd_gray_ptr ^ prev_gray) > 1) begin failures++; $display("FAIL rnd_hamming got=%b prev=%b", bus.rd_gray_ptr, prev_gray); end
          prev_gray = bus.rd_gray_ptr;
        end
        bus.rd_en = 1'b0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_to_empty();
    test_levels();
    test_wrap();
    test_random_ratio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rempty_gen.md
Name: fifo_rempty_gen

Overview:
Read-side status generator for the async FIFO. It sits beside the read pointer counter in the rdclk domain and feeds that counter its rd_empty input. It synchronises the write-domain Gray pointer into rdclk and exports the read Gray pointer to the write domain. From these it produces registered empty, almost-empty and used-word count.

Parameters:
ABITS, 10, RAM address width; pointers are ABITS+1 bits (MSB = wrap bit), depth = 2^ABITS
SYNC_STAGES, 2, flop stages on wr_gray_ptr crossing; legal >= 2
AEMPTY_THR, 4, rd_aempty asserted when used words <= AEMPTY_THR; legal 0..2^ABITS-1

Ports:
rdclk  in  1  read clock
rst  in  1  asynchronous active-high reset
rd_en  in  1  read request, same signal driven to the read pointer counter
rd_bin_ptr  in  ABITS+1  current binary read pointer from the read pointer counter
wr_gray_ptr  in  ABITS+1  registered Gray write pointer from wrclk domain (asynchronous)
rd_gray_ptr  out  ABITS+1  registered Gray read pointer to write domain
rd_empty  out  1  FIFO empty, registered
rd_aempty  out  1  FIFO almost empty, registered
rd_usedw  out  ABITS+1  words available to read, 0..2^ABITS, registered

Behaviour:
- Reset: rst is asynchronous, active-high; clock rdclk. While rst=1: sync chain=0, rd_gray_ptr=0, rd_empty=1, rd_aempty=1, rd_usedw=0. The write domain must be reset in the same window; mid-operation reset discards all content.
- Sync: wr_gray_ptr passes through SYNC_STAGES rdclk flops -> wq_gray; wr_bin_sync = gray2bin(wq_gray), combinational.
- rd_allow = rd_en & ~rd_empty. A read while empty is ignored and no output changes because of it.
- rd_bin_next = rd_bin_ptr + rd_allow, modulo 2^(ABITS+1); natural wrap 2^(ABITS+1)-1 -> 0.
- Every rdclk edge:
  - rd_gray_ptr <= bin2gray(rd_bin_next). It tracks gray(rd_bin_ptr) after every edge and changes at most one bit per cycle.
  - rd_empty <= (bin2gray(rd_bin_next) == wq_gray).
  - rd_usedw <= wr_bin_sync - rd_bin_next, modulo 2^(ABITS+1).
  - rd_aempty <= (that difference <= AEMPTY_THR).
- Latency:
  - Read to status: rd_empty/rd_usedw reflect a read at the same edge the counter increments.
  - Write to status: a change on wr_gray_ptr is visible on rd_empty/rd_usedw after SYNC_STAGES+1 rdclk edges.
- Status is pessimistic: it may report fewer words than actually present, never more, and never reports non-empty for an absent word.
- Full FIFO (rd_usedw = 2^ABITS): pointers differ only in MSB; rd_empty=0.
- Simultaneous read and write-pointer change: the read is applied to rd_bin_next; the write is seen once synchronised. No lost update.
- Elaboration error if SYNC_STAGES < 2 or AEMPTY_THR >= 2^ABITS.

Decomposition:
- Package fifo_async_pkg holds:
  - function bin2gray(ABITS+1)
  - function gray2bin(ABITS+1)
  - the pointer-width constant rule PTR_W = ABITS+1
- The write-side full generator shares this package.
- One sub-module, fifo_gray_sync: parameterised SYNC_STAGES x width flop chain with async reset. It is reused for the rptr-into-wrclk crossing.

Test Plan:
1. ABITS=4, SYNC_STAGES=2, AEMPTY_THR=2; assert rst mid-clock -> immediately rd_empty=1, rd_aempty=1, rd_usedw=0, rd_gray_ptr=00000.
2. rd_bin_ptr=0, wr_gray_ptr 00000->00001 at edge 0 -> rd_empty falls and rd_usedw=1 exactly at edge 3; rd_aempty stays 1.
3. From usedw=1, rd_en=1 one cycle, counter steps rd_bin_ptr to 1 -> next edge rd_empty=1, rd_usedw=0, rd_gray_ptr=00001; hold rd_en=1 three more cycles -> outputs unchanged.
4. rd_bin_ptr=0, wr_gray_ptr=gray(16)=11000 settled -> rd_usedw=16, rd_empty=0, rd_aempty=0; gray(3)=00010 -> usedw=3, aempty=0; gray(2)=00011 -> usedw=2, aempty=1.
5. Wrap: rd_bin_ptr=31, wr_gray_ptr=gray(1)=00001 -> rd_usedw=2; rd_en=1 -> rd_bin_next=0, rd_gray_ptr=00000, rd_usedw=1, rd_empty=0.
6. Random wrclk/rdclk ratios (e.g. 100/37 MHz) with paired writer model -> no read while empty, rd_usedw never exceeds true count or 16, rd_gray_ptr Hamming distance <= 1 between consecutive rdclk edges.
